// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central stall/flush/bubble sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rd,
    input  logic [REG_W-1:0]  ifid_rs1,
    input  logic [REG_W-1:0]  ifid_rs2,
    input  logic              ifid_use_rs2,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    input  logic              dbg_halt,
    input  logic              dbg_step,
    input  logic              dbg_resume,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exmem_en,
    output logic              dbg_halted,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {S_RUN, S_MEM_WAIT, S_HALTED, S_STEP, S_ERROR} state_t;

    state_t              r_state, w_state_nxt;
    state_t              r_ret_state, w_ret_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
    logic [PERF_W-1:0]   r_stall_cnt, r_flush_cnt;
    logic                w_stall_inc, w_flush_inc;
    logic                w_load_use;
    state_t              w_after;

    assign w_load_use = idex_memread && (idex_rd != '0) &&
                        ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));

    // A single STEP cycle falls back to HALTED wherever RUN would have stayed in RUN.
    assign w_after = (r_state == S_STEP) ? S_HALTED : S_RUN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_wait_cnt  <= w_wait_nxt;
            if (w_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (w_flush_inc && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret_state;
        w_wait_nxt  = r_wait_cnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            S_RUN, S_STEP: begin
                if (dmem_busy) begin
                    w_ret_nxt   = w_after;
                    w_state_nxt = S_MEM_WAIT;
                end else if (branch_taken) begin
                    w_flush_inc = 1'b1;
                    w_state_nxt = w_after;
                end else if (w_load_use) begin
                    w_stall_inc = 1'b1;
                    w_state_nxt = w_after;
                end else if (dbg_halt) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = w_after;
                end
            end
            S_MEM_WAIT: begin
                w_stall_inc = 1'b1;
                if (!dmem_busy) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = r_ret_state;
                end else begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 2))
                        w_state_nxt = S_ERROR;
                end
            end
            S_HALTED: begin
                if (dbg_resume)
                    w_state_nxt = S_RUN;
                else if (dbg_step)
                    w_state_nxt = S_STEP;
            end
            default: w_state_nxt = S_ERROR;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        dbg_halted  = (r_state == S_HALTED);
        mem_timeout = (r_state == S_ERROR);
        case (r_state)
            S_RUN, S_STEP: begin
                if (dmem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_load_use || dbg_halt) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            S_HALTED: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
            end
        endcase
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int PERF_W      = 4;
    localparam int CNT_MAX     = (1 << PERF_W) - 1;
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_STEP = 3, M_ERR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, memread, use2, br, busy, halt, step, resume;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, dbg_halted, mem_timeout;
    logic [PERF_W-1:0] stall_cnt, flush_cnt;
    logic [7:0] dut_o;
    assign dut_o = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, dbg_halted, mem_timeout};

    pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .idex_memread(memread), .idex_rd(rd), .ifid_rs1(rs1),
        .ifid_rs2(rs2), .ifid_use_rs2(use2), .branch_taken(br), .dmem_busy(busy),
        .dbg_halt(halt), .dbg_step(step), .dbg_resume(resume), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .dbg_halted(dbg_halted),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_pass = 0, n_total = 0;
    int m_mode = M_RUN, m_wait = 0, m_ret = M_RUN, m_stall = 0, m_flush = 0;
    int n_mode, n_wait, n_ret, n_stall, n_flush;
    logic [7:0] exp_o;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] ex);
        n_total++;
        assert (obs === ex) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, ex);
    endtask

    task automatic chk_int(input string tag, input logic [PERF_W-1:0] obs, input int ex);
        n_total++;
        assert (obs === PERF_W'(ex)) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Outputs packed as {pc, ifid, flush, idex, bubble, exmem, halted, timeout}.
    task automatic model_predict();
        bit lu;
        int after;
        lu = memread && (rd != 0) && ((rd == rs1) || (use2 && (rd == rs2)));
        n_mode = m_mode; n_wait = m_wait; n_ret = m_ret; n_stall = m_stall; n_flush = m_flush;
        exp_o = 8'b1101_0100;
        if (!rst_n) begin
            exp_o = {6'b001010, m_mode == M_HALT, m_mode == M_ERR};
            n_mode = M_RUN; n_wait = 0; n_ret = M_RUN; n_stall = 0; n_flush = 0;
            return;
        end
        case (m_mode)
            M_RUN, M_STEP: begin
                after = (m_mode == M_STEP) ? M_HALT : M_RUN;
                n_mode = after;
                if (busy) begin
                    exp_o = 8'b0; n_ret = after; n_mode = M_WAIT;
                end else if (br) begin
                    exp_o[5] = 1'b1; exp_o[3] = 1'b1; n_flush = sat(m_flush + 1);
                end else if (lu) begin
                    exp_o[7] = 1'b0; exp_o[6] = 1'b0; exp_o[3] = 1'b1; n_stall = sat(m_stall + 1);
                end else if (halt) begin
                    exp_o[7] = 1'b0; exp_o[6] = 1'b0; exp_o[3] = 1'b1; n_mode = M_HALT;
                end
            end
            M_WAIT: begin
                exp_o = 8'b0;
                n_stall = sat(m_stall + 1);
                if (!busy) begin
                    n_mode = m_ret; n_wait = 0;
                end else begin
                    n_wait = m_wait + 1;
                    if (n_wait == MEM_TIMEOUT - 1) n_mode = M_ERR;
                end
            end
            M_HALT: begin
                exp_o = 8'b0001_1110;
                if (resume) n_mode = M_RUN;
                else if (step) n_mode = M_STEP;
            end
            default: exp_o = 8'b0000_0001;
        endcase
    endtask

    task automatic cycle(input string tag);
        #2;
        model_predict();
        chk8({tag, "_out"}, dut_o, exp_o);
        @(posedge clk);
        #1;
        m_mode = n_mode; m_wait = n_wait; m_ret = n_ret; m_stall = n_stall; m_flush = n_flush;
        chk_int({tag, "_stall"}, stall_cnt, m_stall);
        chk_int({tag, "_flush"}, flush_cnt, m_flush);
    endtask

    task automatic idle();
        rst_n = 1'b1; memread = 1'b0; rd = '0; rs1 = '0; rs2 = '0; use2 = 1'b0;
        br = 1'b0; busy = 1'b0; halt = 1'b0; step = 1'b0; resume = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        cycle("reset");
        idle();

        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; use2 = 1'b1;
        cycle("lu_add");
        chk_int("lu_add_stall1", stall_cnt, 1);
        memread = 1'b0; rd = 5'd0;
        cycle("lu_bubble_gone");

        memread = 1'b1; rd = 5'd0; rs1 = 5'd0;
        cycle("lu_x0");
        rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; use2 = 1'b0;
        cycle("lu_rs2_unused");

        rd = 5'd7; rs1 = 5'd7; br = 1'b1;
        cycle("br_over_lu");
        chk_int("br_flush1", flush_cnt, 1);
        chk_int("br_stall_kept", stall_cnt, 1);

        idle();
        br = 1'b1; busy = 1'b1;
        for (int i = 0; i < 3; i++) cycle("busy_br");
        busy = 1'b0;
        cycle("busy_exit");
        cycle("busy_flush");
        chk_int("busy_stall", stall_cnt, 4);
        chk_int("busy_flush2", flush_cnt, 2);

        idle();
        busy = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) cycle("timeout_wait");
        chk8("timeout_err", {7'b0, mem_timeout}, 8'd1);
        chk_int("timeout_stall_sat", stall_cnt, CNT_MAX);
        cycle("error_stuck");
        rst_n = 1'b0;
        cycle("error_reset");
        idle();
        chk_int("after_reset_stall", stall_cnt, 0);

        halt = 1'b1;
        cycle("halt_req");
        halt = 1'b0;
        cycle("halted_idle");
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            cycle("halted_step_req");
            step = 1'b0;
            cycle("step_cycle");
            chk8("step_back_halted", {7'b0, dbg_halted}, 8'd1);
        end
        step = 1'b1; resume = 1'b1;
        cycle("resume_wins");
        step = 1'b0; resume = 1'b0;
        chk8("resume_unhalted", {7'b0, dbg_halted}, 8'd0);
        cycle("run_again");

        halt = 1'b1;
        cycle("halt2");
        halt = 1'b0; step = 1'b1;
        cycle("step2_req");
        step = 1'b0; busy = 1'b1;
        cycle("step_busy");
        busy = 1'b0;
        cycle("step_busy_exit");
        chk8("step_busy_ret_halted", {7'b0, dbg_halted}, 8'd1);
        resume = 1'b1;
        cycle("resume2");
        idle();

        for (int i = 0; i < 800; i++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            memread = $urandom_range(0, 1);
            rd      = REG_W'($urandom_range(0, 3));
            rs1     = REG_W'($urandom_range(0, 3));
            rs2     = REG_W'($urandom_range(0, 3));
            use2    = $urandom_range(0, 1);
            br      = ($urandom_range(0, 4) == 0);
            busy    = (m_mode == M_WAIT) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            halt    = ($urandom_range(0, 9) == 0);
            step    = ($urandom_range(0, 3) == 0);
            resume  = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
